// File: rtl/tdm_fir_engine.sv
// Time-shared FIR: NUM_MACS multiplier-accumulators sweep TPM phases per sample,
// then a registered adder, round-half-up, and saturation produce one output sample.
module tdm_fir_engine #(
  parameter int DATA_W    = 18,
  parameter int COEFF_W   = 18,
  parameter int NUM_TAPS  = 81,
  parameter int NUM_MACS  = 5,
  parameter int OUT_SHIFT = 18
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          sam_clk_en,
  input  logic signed [DATA_W-1:0]                      x_in,
  input  logic                                          coef_we,
  input  logic [(NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1)-1:0] coef_addr,
  input  logic signed [COEFF_W-1:0]                     coef_data,
  input  logic                                          coef_swap,
  output logic signed [DATA_W-1:0]                      y,
  output logic                                          y_valid,
  output logic                                          busy,
  output logic                                          sat,
  output logic                                          overrun
);

  localparam int TPM    = (NUM_TAPS + NUM_MACS - 1) / NUM_MACS;
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
  localparam int P_W    = (TPM > 1) ? $clog2(TPM) : 1;
  localparam int ADDR_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) <<< RND_SH) : '0;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MINV = -MAXV - (ACC_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SUM   = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0]  xline    [NUM_TAPS];
  logic signed [COEFF_W-1:0] h_shadow [NUM_TAPS];
  logic signed [COEFF_W-1:0] h_active [NUM_TAPS];
  logic signed [PROD_W-1:0]  prod_nxt [NUM_MACS];
  logic signed [PROD_W-1:0]  prod     [NUM_MACS];
  logic signed [ACC_W-1:0]   acc      [NUM_MACS];

  logic [P_W-1:0]           phase;
  logic                     last_phase, fire, do_swap, swap_pending;
  logic                     prod_vld, prod_first;
  logic signed [ACC_W-1:0]  sum_all, sum_r;
  logic signed [ACC_W:0]    sum_ext, rnd;
  logic signed [DATA_W-1:0] y_nxt;
  logic                     clip;

  // FSM: a strobe in any state (re)starts a pass from phase 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    last_phase = (phase == P_W'(TPM - 1));
    case (state)
      IDLE:    if (sam_clk_en) state_nxt = RUN;
      RUN:     if (last_phase) state_nxt = DRAIN;
      DRAIN:   state_nxt = SUM;
      SUM:     state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (sam_clk_en) state_nxt = RUN;
    fire    = (state == OUT) && !sam_clk_en;
    do_swap = (coef_swap || swap_pending) && ((state == IDLE) || fire);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (sam_clk_en) begin
      phase <= '0;
    end else if (state == RUN) begin
      phase <= last_phase ? '0 : phase + P_W'(1);
    end
  end

  // Delay line and coefficient banks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        xline[i]    <= '0;
        h_shadow[i] <= '0;
        h_active[i] <= '0;
      end
      swap_pending <= 1'b0;
    end else begin
      if (sam_clk_en) begin
        xline[0] <= x_in;
        for (int i = 1; i < NUM_TAPS; i++) xline[i] <= xline[i-1];
      end
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (coef_we && coef_addr == ADDR_W'(i)) h_shadow[i] <= coef_data;
        if (do_swap) h_active[i] <= h_shadow[i];
      end
      swap_pending <= (swap_pending || coef_swap) && !do_swap;
    end
  end

  // MAC k covers taps k*TPM .. k*TPM+TPM-1; taps past the end read as zero
  for (genvar k = 0; k < NUM_MACS; k++) begin : g_mac
    logic signed [DATA_W-1:0]  xs [TPM];
    logic signed [COEFF_W-1:0] hs [TPM];
    logic signed [PROD_W-1:0]  xa, ha;
    for (genvar j = 0; j < TPM; j++) begin : g_phase
      if (k*TPM + j < NUM_TAPS) begin : g_tap
        assign xs[j] = xline[k*TPM + j];
        assign hs[j] = h_active[k*TPM + j];
      end else begin : g_pad
        assign xs[j] = '0;
        assign hs[j] = '0;
      end
    end
    assign xa          = xs[phase];
    assign ha          = hs[phase];
    assign prod_nxt[k] = xa * ha;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_MACS; k++) begin
        prod[k] <= '0;
        acc[k]  <= '0;
      end
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_MACS; k++) begin
        if (state == RUN) prod[k] <= prod_nxt[k];
        if (prod_vld) acc[k] <= prod_first ? ACC_W'(prod[k]) : acc[k] + ACC_W'(prod[k]);
      end
      prod_vld   <= (state == RUN);
      prod_first <= (state == RUN) && (phase == '0);
    end
  end

  always_comb begin
    sum_all = '0;
    for (int k = 0; k < NUM_MACS; k++) sum_all = sum_all + acc[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              sum_r <= '0;
    else if (state == SUM)  sum_r <= sum_all;
  end

  // One guard bit keeps the rounding offset from wrapping
  always_comb begin
    sum_ext = sum_r;
    rnd     = (sum_ext + RND) >>> OUT_SHIFT;
    clip    = 1'b1;
    if (rnd > MAXV)      y_nxt = {1'b0, {(DATA_W-1){1'b1}}};
    else if (rnd < MINV) y_nxt = {1'b1, {(DATA_W-1){1'b0}}};
    else begin
      y_nxt = rnd[DATA_W-1:0];
      clip  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y       <= '0;
      y_valid <= 1'b0;
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= fire;
      sat     <= fire && clip;
      if (fire) y <= y_nxt;
      if (sam_clk_en && busy) overrun <= 1'b1;
    end
  end

endmodule
